// File: rtl/cam_frame_tx_if.sv
// Camera pixel bus plus the frame-RAM read port owned by cam_frame_tx.
// The master side drives the bus; the slave side is the RAM/receiver.
interface cam_frame_tx_if;
  logic [15:0] rdaddr;
  logic        rden;
  logic [2:0]  q;
  logic        pclk;
  logic        vsync;
  logic        href;
  logic [2:0]  d;

  modport master (
    output rdaddr, rden, pclk, vsync, href, d,
    input  q
  );

  modport slave (
    input  rdaddr, rden, pclk, vsync, href, d,
    output q
  );
endinterface

// File: rtl/cam_frame_tx.sv
// Replays the frame RAM as an OV-style pclk/vsync/href/d stream.
// Define TEST_PATTERN_EN to add the internal colour-bar source.
module cam_frame_tx #(
  parameter int H_ACTIVE = 256,
  parameter int V_ACTIVE = 240,
  parameter int H_BLANK  = 64,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 10,
  parameter int V_FRONT  = 2
) (
  input  logic sysclk,
  input  logic reset,
  input  logic en,
  input  logic pat_sel,
  cam_frame_tx_if.master bus,
  output logic busy,
  output logic frame_done
);
  localparam int H_TOT = H_ACTIVE + H_BLANK;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_ACTIVE + V_SYNC
                             + V_BACK + V_FRONT + 1);
  localparam int CW = $clog2(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] VS_LAST = VW'(V_SYNC - 1);
  localparam logic [VW-1:0] VB_LAST = VW'(V_BACK - 1);
  localparam logic [VW-1:0] VA_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VF_LAST = VW'(V_FRONT - 1);
  localparam logic [15:0] PIX_LAST =
    16'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VS, S_VB, S_ACT, S_VF
  } state_t;

  state_t        r_state;
  logic          r_ph;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          r_vsync;
  logic          r_href;
  logic [2:0]    r_d;
  logic [15:0]   r_addr;
  logic          r_busy;
  logic          r_fdone;

  state_t        w_ns;
  logic [HW-1:0] w_nh;
  logic [VW-1:0] w_nv;
  logic          w_eol;
  logic          w_start;
  logic          w_fend;
  logic          w_act_n;
  logic          w_rden;
  logic [2:0]    w_pix;

  // Everything below describes the pixel period that the
  // next fall edge (r_ph=1) will start.
  always_comb begin
    w_ns    = r_state;
    w_nh    = r_h + HW'(1);
    w_nv    = r_v;
    w_start = 1'b0;
    w_fend  = 1'b0;
    w_eol   = (r_h == H_LAST);
    if (w_eol) begin
      w_nh = '0;
      w_nv = r_v + VW'(1);
    end
    unique case (r_state)
      S_IDLE: begin
        w_nh = '0;
        w_nv = '0;
        if (en) begin
          w_ns    = S_VS;
          w_start = 1'b1;
        end
      end
      S_VS:
        if (w_eol && r_v == VS_LAST) begin
          w_ns = S_VB;
          w_nv = '0;
        end
      S_VB:
        if (w_eol && r_v == VB_LAST) begin
          w_ns = S_ACT;
          w_nv = '0;
        end
      S_ACT:
        if (w_eol && r_v == VA_LAST) begin
          w_ns = S_VF;
          w_nv = '0;
        end
      S_VF:
        if (w_eol && r_v == VF_LAST) begin
          w_nv   = '0;
          w_fend = 1'b1;
          if (en) begin
            w_ns    = S_VS;
            w_start = 1'b1;
          end else begin
            w_ns = S_IDLE;
          end
        end
      default: w_ns = S_IDLE;
    endcase
    w_act_n = (w_ns == S_ACT) && (w_nh < H_ACT);
  end

`ifdef TEST_PATTERN_EN
  logic       r_pat;
  logic [2:0] w_col;

  assign w_col  = w_nh[CW-1 -: 3];
  assign w_pix  = r_pat ? w_col : bus.q;
  assign w_rden = ~r_ph & w_act_n & ~r_pat;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)
      r_pat <= 1'b0;
    else if (r_ph && w_start)
      r_pat <= pat_sel;
  end
`else
  logic w_unused;

  assign w_unused = pat_sel;
  assign w_pix    = bus.q;
  assign w_rden   = ~r_ph & w_act_n;
`endif

  // RAM samples rdaddr on the rise edge; q is then
  // stable for the fall edge that loads d.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ph    <= 1'b0;
      r_h     <= '0;
      r_v     <= '0;
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_d     <= '0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_fdone <= 1'b0;
    end else begin
      r_ph    <= ~r_ph;
      r_fdone <= 1'b0;
      if (r_ph) begin
        r_state <= w_ns;
        r_h     <= w_nh;
        r_v     <= w_nv;
        r_vsync <= (w_ns == S_VS);
        r_href  <= w_act_n;
        r_d     <= w_act_n ? w_pix : 3'd0;
        r_busy  <= (w_ns != S_IDLE);
        r_fdone <= w_fend;
        if (w_start)
          r_addr <= '0;
      end else if (w_act_n && r_addr != PIX_LAST) begin
        r_addr <= r_addr + 16'd1;
      end
    end
  end

  assign bus.pclk   = r_ph;
  assign bus.vsync  = r_vsync;
  assign bus.href   = r_href;
  assign bus.d      = r_d;
  assign bus.rdaddr = r_addr;
  assign bus.rden   = w_rden;
  assign busy       = r_busy;
  assign frame_done = r_fdone;
endmodule

// File: tb/tb_cam_frame_tx.sv
// Bench for cam_frame_tx with a small frame geometry and a RAM model.
// Build with TEST_PATTERN_EN defined to also cover the colour bars.
module tb_cam_frame_tx;
  localparam int HA  = 16;
  localparam int VA  = 6;
  localparam int HB  = 4;
  localparam int VSN = 2;
  localparam int VBK = 2;
  localparam int VFR = 1;
  localparam int HT    = HA + HB;
  localparam int LINES = VSN + VBK + VA + VFR;
  localparam int FRAME = 2 * HT * LINES;
  localparam int PIX   = HA * VA;
  localparam int CSH   = $clog2(HA) - 3;

  typedef struct {
    int nfr;
    int e_fd;
    int e_lines;
    int e_rden;
    int e_vscyc;
    int e_busy;
    int e_vsr;
  } row_t;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  logic en     = 1'b0;
  logic pat_sel = 1'b0;
  logic busy;
  logic frame_done;

  cam_frame_tx_if bus();

  cam_frame_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .V_SYNC(VSN), .V_BACK(VBK), .V_FRONT(VFR)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .en(en),
    .pat_sel(pat_sel),
    .bus(bus),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 sysclk = ~sysclk;

  function automatic logic [2:0] ram_f(input logic [15:0] a);
    return a[2:0] ^ a[5:3];
  endfunction

  always @(posedge sysclk)
    if (bus.rden) bus.q <= ram_f(bus.rdaddr);

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0, vs_cyc = 0, vs_rise = 0, href_n = 0;
  int rden_n = 0, fd_n = 0, busy_cyc = 0;
  int hw = 0, col = 0, exp_idx = 0, last_fd = 0;
  bit p_vs = 0, p_href = 0, p_fd = 0;
  bit have_fd = 0, gap = 1, pat_active = 0;
  logic [2:0] sb[$];

  task automatic check(input string nm, input int act,
                       input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic mon_step();
    logic [2:0] e;
    cyc++;
    if (reset) begin
      sb.delete();
      exp_idx = 0;
      p_vs = 0; p_href = 0; p_fd = 0;
      have_fd = 0; gap = 1;
      return;
    end
    if (bus.vsync) vs_cyc++;
    if (bus.vsync && !p_vs) begin
      vs_rise++;
      exp_idx = 0;
    end
    if (bus.href && !p_href) begin
      href_n++;
      hw = 0;
      col = 0;
    end
    if (bus.href) hw++;
    if (!bus.href && p_href) check("href_width", hw, 2 * HA);
    if (!bus.href) check("d_blank", bus.d, 0);
    if (pat_active) check("rden_pat", bus.rden, 0);
    if (bus.rden) begin
      rden_n++;
      check("rdaddr", bus.rdaddr, exp_idx);
      sb.push_back(ram_f(16'(exp_idx)));
      exp_idx++;
    end
    if (busy) busy_cyc++;
    else gap = 1;
    if (frame_done) begin
      fd_n++;
      if (have_fd && !gap)
        check("frame_period", cyc - last_fd, FRAME);
      if (p_fd) check("fd_width", 2, 1);
      have_fd = 1;
      last_fd = cyc;
      gap = 0;
    end
    if (bus.pclk && bus.href) begin
      if (pat_active) begin
        check("bar", bus.d, (col >> CSH) & 7);
      end else if (sb.size() == 0) begin
        check("sb_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        check("pixel", bus.d, e);
      end
      col++;
    end
    p_vs = bus.vsync;
    p_href = bus.href;
    p_fd = frame_done;
  endtask

  task automatic wait_idle(input int lim);
    int t = 0;
    while (busy && t < lim) begin
      @(negedge sysclk);
      t++;
    end
    check("busy_timeout", busy, 0);
  endtask

  task automatic run_frames(input int n);
    int base;
    int t;
    base = fd_n;
    en = 1'b1;
    t = 0;
    do begin
      @(negedge sysclk);
      t++;
    end while (!bus.vsync && t < 8);
    check("vs_start", bus.vsync, 1);
    check("vs_latency_ok", int'(t <= 2), 1);
    t = 0;
    while (fd_n - base < n - 1 && t < n * FRAME) begin
      @(negedge sysclk);
      t++;
    end
    en = 1'b0;
    wait_idle(n * FRAME + 10);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pclk"}, bus.pclk, 0);
    check({tag, "_vsync"}, bus.vsync, 0);
    check({tag, "_href"}, bus.href, 0);
    check({tag, "_d"}, bus.d, 0);
    check({tag, "_rdaddr"}, bus.rdaddr, 0);
    check({tag, "_rden"}, bus.rden, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fdone"}, frame_done, 0);
  endtask

  initial begin
    row_t rows[3];
    int b_fd, b_ln, b_rd, b_vc, b_bc, b_vr, t;
    fork
      forever begin
        @(negedge sysclk);
        mon_step();
      end
    join_none

    for (int i = 0; i < 3; i++) begin
      rows[i].nfr     = i + 1;
      rows[i].e_fd    = i + 1;
      rows[i].e_lines = (i + 1) * VA;
      rows[i].e_rden  = (i + 1) * PIX;
      rows[i].e_vscyc = (i + 1) * VSN * 2 * HT;
      rows[i].e_busy  = (i + 1) * FRAME;
      rows[i].e_vsr   = i + 1;
    end

    repeat (3) @(negedge sysclk);
    check_zero("rst");
    @(negedge sysclk);
    reset = 1'b0;
    repeat (4) @(negedge sysclk);

    for (int i = 0; i < 3; i++) begin
      b_fd = fd_n; b_ln = href_n; b_rd = rden_n;
      b_vc = vs_cyc; b_bc = busy_cyc; b_vr = vs_rise;
      run_frames(rows[i].nfr);
      repeat (50) @(negedge sysclk);
      check("row_fd", fd_n - b_fd, rows[i].e_fd);
      check("row_lines", href_n - b_ln, rows[i].e_lines);
      check("row_rden", rden_n - b_rd, rows[i].e_rden);
      check("row_vscyc", vs_cyc - b_vc, rows[i].e_vscyc);
      check("row_busy", busy_cyc - b_bc, rows[i].e_busy);
      check("row_vsrise", vs_rise - b_vr, rows[i].e_vsr);
      check("row_addr_hold", bus.rdaddr, PIX - 1);
      check("row_sb_left", sb.size(), 0);
    end

    b_fd = fd_n; b_ln = href_n; b_vr = vs_rise;
    en = 1'b1;
    t = 0;
    while (href_n - b_ln < 3 && t < FRAME) begin
      @(negedge sysclk);
      t++;
    end
    en = 1'b0;
    wait_idle(FRAME);
    repeat (2 * FRAME) @(negedge sysclk);
    check("drop_lines", href_n - b_ln, VA);
    check("drop_fd", fd_n - b_fd, 1);
    check("drop_vsrise", vs_rise - b_vr, 1);
    check("drop_busy", busy, 0);

    b_ln = href_n;
    en = 1'b1;
    t = 0;
    while (href_n - b_ln < 4 && t < FRAME) begin
      @(negedge sysclk);
      t++;
    end
    #2 reset = 1'b1;
    #1 check_zero("midrst");
    @(negedge sysclk);
    reset = 1'b0;
    b_fd = fd_n; b_ln = href_n; b_rd = rden_n;
    @(posedge sysclk);
    #1 check("rel_vs_rise_edge", bus.vsync, 0);
    @(posedge sysclk);
    #1 check("rel_vs_fall_edge", bus.vsync, 1);
    check("rel_rdaddr", bus.rdaddr, 0);
    check("rel_busy", busy, 1);
    @(negedge sysclk);
    en = 1'b0;
    wait_idle(FRAME + 10);
    repeat (10) @(negedge sysclk);
    check("rel_lines", href_n - b_ln, VA);
    check("rel_rden", rden_n - b_rd, PIX);
    check("rel_fd", fd_n - b_fd, 1);
    check("rel_addr", bus.rdaddr, PIX - 1);

`ifdef TEST_PATTERN_EN
    pat_sel = 1'b1;
    pat_active = 1'b1;
    b_rd = rden_n; b_ln = href_n;
    run_frames(1);
    repeat (10) @(negedge sysclk);
    check("pat_rden", rden_n - b_rd, 0);
    check("pat_lines", href_n - b_ln, VA);
    check("pat_addr", bus.rdaddr, PIX - 1);
    pat_sel = 1'b0;
    pat_active = 1'b0;
`endif

    check("end_sb_left", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cam_frame_tx.md
# cam_frame_tx

Camera-bus transmitter that plays a stored frame out of the right-camera frame RAM as an OV-style pixel stream (pclk, vsync, href, d[2:0]). It drives the same bus that the camera-to-RAM capture path receives. This lets the capture → RAM → VGA chain be closed in loopback, and lets one board act as the camera source for another. It owns the RAM read port and runs entirely in the sysclk domain.

## Interface
- H_ACTIVE, 256: active pixels per line; power of two ≥ 8
- V_ACTIVE, 240: active lines per frame; H_ACTIVE*V_ACTIVE ≤ 65536
- H_BLANK, 64: pixel periods per line with href low
- V_SYNC, 3: lines with vsync high
- V_BACK, 10: blank lines after vsync
- V_FRONT, 2: blank lines after the last active line
- sysclk  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high
- en  in  1  level; run frames back-to-back while high
- pat_sel  in  1  1 = internal test pattern (only with TEST_PATTERN_EN)
- q  in  3  RAM read data; valid one sysclk after rden
- rdaddr  out  16  RAM read address
- rden  out  1  RAM read enable
- pclk  out  1  pixel clock = sysclk/2
- vsync  out  1  frame sync, active-high
- href  out  1  line valid, active-high
- d  out  3  pixel data
- busy  out  1  high from frame start to frame end
- frame_done  out  1  one-sysclk pulse at the end of each frame

## Operation
- Phase bit `ph` toggles every sysclk from reset, free-running. pclk = ph.
- Rise edge: sysclk edge where ph goes 0→1. Fall edge: sysclk edge where ph goes 1→0.
- vsync, href, d and the line/pixel counters update only on fall edges. A receiver samples on pclk rising.
- States:
  - IDLE
  - VS: V_SYNC lines
  - VB: V_BACK lines
  - ACT: V_ACTIVE lines
  - VF: V_FRONT lines
- Each line is H_ACTIVE+H_BLANK pixel periods.
- IDLE → VS on a fall edge with en=1. busy rises and rdaddr is cleared to 0 on that edge.
- VS → VB → ACT → VF: each transition occurs when the line counter reaches the state's line count.
- End of VF:
  - frame_done pulses.
  - If en=1, go to VS (no gap, busy stays 1).
  - Otherwise go to IDLE and busy drops.
- en is sampled only at the end of VF and in IDLE. Deasserting en mid-frame finishes the current frame.
- vsync = 1 for the whole of VS. href = 0 outside ACT.
- In ACT, href = 1 for pixel periods 0..H_ACTIVE-1 of each line, then 0 for H_BLANK periods.
- Read pipeline:
  - On the rise edge preceding each active pixel period, drive rdaddr = pixel index and set rden=1.
  - On the following fall edge, register q into d.
  - rden is 0 on all other cycles.
- The pixel index is linear row*H_ACTIVE+col, running 0..H_ACTIVE*V_ACTIVE-1. After the last pixel it holds until the next frame start clears it.
- d = 0 whenever href = 0.

## Timing
- Reset values: ph 0, pclk 0, vsync 0, href 0, d 0, rdaddr 0, rden 0, busy 0, frame_done 0, state IDLE.
- Reset mid-frame returns all outputs to these values immediately (asynchronous). The next frame restarts at VS.
- Latency from en rising (seen on a fall edge) to vsync high: that same fall edge.
- RAM latency is exactly 1 sysclk. The first active pixel's read is issued 1 sysclk before href rises.
- Frame length in sysclk cycles: 2*(H_ACTIVE+H_BLANK)*(V_SYNC+V_BACK+V_ACTIVE+V_FRONT). With defaults: 2*320*255 = 163200.
- frame_done is asserted on the fall edge that ends the last VF line, for one sysclk only.

## Configuration
- TEST_PATTERN_EN defined:
  - While pat_sel=1, d = column index bits [log2(H_ACTIVE)-1 : log2(H_ACTIVE)-3], giving 8 vertical colour bars.
  - rden stays 0. rdaddr still counts, unchanged.
  - pat_sel is sampled at frame start and held for the whole frame.
- TEST_PATTERN_EN undefined:
  - The pattern logic is absent, pat_sel is ignored, and d always comes from q.

## Test plan
- Reset, en=1 held, defaults:
  - vsync high for exactly 3*640 sysclk.
  - 240 href pulses per frame, each 512 sysclk wide.
  - frame_done every 163200 sysclk.
- RAM model returning q = addr[2:0]:
  - Pixel n shows d = n mod 8 at pclk rising.
  - rdaddr reaches 61439 on the last active pixel.
  - rden pulses exactly 61440 times per frame.
- en dropped midway through ACT:
  - The frame completes with all 240 lines.
  - frame_done pulses once, busy falls, and no further vsync appears.
- reset asserted during ACT line 100:
  - All outputs go to 0 asynchronously.
  - After release with en=1, vsync rises on the first fall edge and rdaddr restarts at 0.
- TEST_PATTERN_EN defined, pat_sel=1:
  - Line 0 pixels 0..31 have d=0, pixels 32..63 have d=1, …, pixels 224..255 have d=7.
  - rden never asserts.
- Loopback into the capture block: the RAM written by the capture path matches the source frame word-for-word after one full frame.
